// File: rtl/hsi_stream_pkg.sv
// Shared definitions for the gyro HSI stream path: payload width, nominal packet
// length, write-side state encoding and pointer sizing.
package hsi_stream_pkg;

  localparam int DATA_W      = 32;
  localparam int HSI_PKT_LEN = 9;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PKT  = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  // One extra MSB distinguishes full from empty when the address bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hsi_sdp_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous (combinational) read.
module hsi_sdp_ram #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hsi_packet_fifo.sv
// Store-and-forward packet buffer behind the HSI packetizer: only whole packets
// reach the master side; packets that overflow or exceed MAX_PKT are dropped whole.
//
// state   | meaning
// WR_IDLE | between packets, next beat starts a new packet
// WR_PKT  | writing a packet speculatively, not yet committed
// WR_DROP | discarding the rest of a rejected packet until tlast
module hsi_packet_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int MAX_PKT = 9,
  parameter int CNT_W   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         pkt_count,
  output logic [CNT_W-1:0]         drop_count
);
  import hsi_stream_pkg::*;

  localparam int PW   = ptr_w(DEPTH);
  localparam int AW   = $clog2(DEPTH);
  localparam int WC_W = $clog2(MAX_PKT + 1);

  wr_state_t       state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_q, commit_d;
  logic [PW-1:0]   rd_ptr_q;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] pkt_count_q, drop_count_q;
  logic            we, pkt_inc, drop_inc, full, rd_fire;
  logic [DATA_W:0] rdata;

  assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign m_tvalid = (rd_ptr_q != commit_q);
  assign rd_fire  = m_tvalid & m_tready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    wcnt_d   = wcnt_q;
    we       = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    if (s_tvalid) begin
      case (state_q)
        WR_IDLE: begin
          if (!full) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            wcnt_d   = WC_W'(1);
            if (s_tlast) begin
              commit_d = wr_ptr_q + PW'(1);
              pkt_inc  = 1'b1;
            end else begin
              state_d = WR_PKT;
            end
          end else if (s_tlast) begin
            drop_inc = 1'b1;
          end else begin
            state_d = WR_DROP;
          end
        end
        WR_PKT: begin
          // Any beat after MAX_PKT words already stored makes the packet too long.
          if (full || (wcnt_q == WC_W'(MAX_PKT))) begin
            wr_ptr_d = commit_q;
            if (s_tlast) begin
              drop_inc = 1'b1;
              state_d  = WR_IDLE;
            end else begin
              state_d = WR_DROP;
            end
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            wcnt_d   = wcnt_q + WC_W'(1);
            if (s_tlast) begin
              commit_d = wr_ptr_q + PW'(1);
              pkt_inc  = 1'b1;
              state_d  = WR_IDLE;
            end
          end
        end
        WR_DROP: begin
          if (s_tlast) begin
            drop_inc = 1'b1;
            state_d  = WR_IDLE;
          end
        end
        default: state_d = WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= '0;
      commit_q     <= '0;
      rd_ptr_q     <= '0;
      wcnt_q       <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      wcnt_q   <= wcnt_d;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (pkt_inc) pkt_count_q <= pkt_count_q + CNT_W'(1);
      if (drop_inc && (drop_count_q != '1)) drop_count_q <= drop_count_q + CNT_W'(1);
    end
  end

  hsi_sdp_ram #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({s_tlast, s_tdata}),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  assign m_tdata    = rdata[DATA_W-1:0];
  assign m_tlast    = rdata[DATA_W];
  assign level      = commit_q - rd_ptr_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_hsi_packet_fifo.sv
// Scoreboard bench for hsi_packet_fifo: stimulus queues expected output beats,
// a negedge monitor compares every presented word against the queue head.
module tb_hsi_packet_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [5:0]  level;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;

  int passed = 0;
  int total  = 0;
  logic [32:0] sb[$];

  always #5 clock = ~clock;

  hsi_packet_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .level      (level),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Word presented on the negedge transfers on the following posedge when ready.
  always @(negedge clock) begin
    logic [32:0] head;
    if (reset === 1'b0 && m_tvalid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", m_tdata, m_tlast);
      end else begin
        chk("out_beat", {31'd0, m_tlast, m_tdata}, {31'd0, sb[0]});
        if (m_tready) head = sb.pop_front();
      end
    end
  end

  task automatic send_pkt(input logic [31:0] base, input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 32'(i);
      s_tlast  = (i == n - 1);
      if (push) sb.push_back({s_tlast, s_tdata});
      @(posedge clock); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || m_tvalid) && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({name, "_valid_low"}, 64'(m_tvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 64'(m_tvalid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // 1: single 9-word packet, valid exactly one cycle after the tlast edge
    for (int i = 0; i < 9; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'h100 + 32'(i);
      s_tlast  = (i == 8);
      sb.push_back({s_tlast, s_tdata});
      if (i == 8) chk("t1_valid_before_commit", 64'(m_tvalid), 64'd0);
      @(posedge clock); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("t1_valid_after_commit", 64'(m_tvalid), 64'd1);
    chk("t1_level_commit", 64'(level), 64'd9);
    wait_drain("t1");
    chk("t1_pkt", 64'(pkt_count), 64'd1);
    chk("t1_level", 64'(level), 64'd0);

    // 2: three packets stored while stalled, then released
    m_tready = 1'b0;
    send_pkt(32'h200, 9, 1'b1);
    send_pkt(32'h210, 9, 1'b1);
    send_pkt(32'h220, 9, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("t2_level", 64'(level), 64'd27);
    chk("t2_pkt", 64'(pkt_count), 64'd4);
    chk("t2_drop", 64'(drop_count), 64'd0);
    m_tready = 1'b1;
    wait_drain("t2");

    // 3: fourth packet overflows at word 6 and is rewound
    m_tready = 1'b0;
    send_pkt(32'h300, 9, 1'b1);
    send_pkt(32'h310, 9, 1'b1);
    send_pkt(32'h320, 9, 1'b1);
    send_pkt(32'h330, 9, 1'b0);
    chk("t3_level", 64'(level), 64'd27);
    chk("t3_drop", 64'(drop_count), 64'd1);
    chk("t3_pkt", 64'(pkt_count), 64'd7);
    m_tready = 1'b1;
    wait_drain("t3");
    repeat (5) @(posedge clock);
    #1;
    chk("t3_no_4th", 64'(m_tvalid), 64'd0);

    // 4: 10-word packet exceeds MAX_PKT
    send_pkt(32'h400, 10, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("t4_drop", 64'(drop_count), 64'd2);
    chk("t4_pkt", 64'(pkt_count), 64'd7);
    chk("t4_level", 64'(level), 64'd0);
    chk("t4_valid", 64'(m_tvalid), 64'd0);

    // 5: back-to-back packets; the second commits on the edge reading the first's last word
    send_pkt(32'h500, 9, 1'b1);
    send_pkt(32'h510, 9, 1'b1);
    chk("t5_level_overlap", 64'(level), 64'd9);
    wait_drain("t5");
    chk("t5_pkt", 64'(pkt_count), 64'd9);

    // 6: reset during word 4 of a packet, then a clean packet
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'h600 + 32'(i);
      s_tlast  = 1'b0;
      if (i == 3) reset = 1'b1;
      @(posedge clock); #1;
    end
    s_tvalid = 1'b0;
    reset    = 1'b0;
    chk("t6_rst_valid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_level", 64'(level), 64'd0);
    chk("t6_rst_pkt", 64'(pkt_count), 64'd0);
    chk("t6_rst_drop", 64'(drop_count), 64'd0);
    send_pkt(32'h700, 9, 1'b1);
    wait_drain("t6");
    chk("t6_pkt", 64'(pkt_count), 64'd1);
    chk("t6_drop", 64'(drop_count), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
